// File: rtl/prefix_sub_pkg.sv
// Shared types and constants for the digit-serial prefix subtractor.
// No logic; holds the FSM encoding, default sizing and the digit-count helper.
// Not applicable: package only.
package prefix_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_e;

    localparam int SUB_WIDTH = 12;
    localparam int SUB_DIGIT = 4;

    function automatic int sub_ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/prefix_sub_digit.sv
// One DIGIT-bit slice of a - b - bin with Brent-Kung borrow lookahead.
// Latency: purely combinational.
// Backpressure: none; the slice has no handshake.
module prefix_sub_digit
    import prefix_sub_pkg::*;
#(
    parameter int DIGIT = SUB_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    localparam int TOP = 1 << $clog2(DIGIT);

    logic [DIGIT-1:0] gen;
    logic [DIGIT-1:0] prop;
    logic [DIGIT-1:0] grp;
    logic [DIGIT:0]   brw;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign gen  = ~a & b;
    assign prop = ~(a ^ b);

    always_comb begin
        logic [DIGIT-1:0] gg;
        logic [DIGIT-1:0] pp;
        gg    = gen;
        pp    = prop;
        gg[0] = gen[0] | (prop[0] & bin);
        for (int s = 1; s < DIGIT; s = s * 2) begin
            for (int i = 2 * s - 1; i < DIGIT; i += 2 * s) begin
                gg[i] = gg[i] | (pp[i] & gg[i-s]);
                pp[i] = pp[i] & pp[i-s];
            end
        end
        for (int s = TOP; s >= 1; s = s / 2) begin
            for (int i = 3 * s - 1; i < DIGIT; i += 2 * s) begin
                gg[i] = gg[i] | (pp[i] & gg[i-s]);
                pp[i] = pp[i] & pp[i-s];
            end
        end
        grp = gg;
    end

    assign brw  = {grp, bin};
    assign d    = a ^ b ^ brw[DIGIT-1:0];
    assign bout = brw[DIGIT];

endmodule

// File: rtl/prefix_sub_serial.sv
// Recovers the unknown operand from an adder sum, DIGIT bits per cycle, LSB first; flags impossible sums.
// Latency: result valid NDIG+1 edges after in_valid is presented in IDLE; one result per NDIG+2 cycles.
// Backpressure: in_ready low in RUN/DONE; result held in DONE until out_ready. PREFIX_SUB_ERRCNT_EN adds err_cnt_o.
module prefix_sub_serial
    import prefix_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int DIGIT = SUB_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] addend_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_o,
`ifdef PREFIX_SUB_ERRCNT_EN
    output logic             err_o,
    output logic [7:0]       err_cnt_o
`else
    output logic             err_o
`endif
);

    localparam int NDIG = sub_ndig(WIDTH, DIGIT);
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("prefix_sub_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    sub_state_e       state;
    logic [WIDTH-1:0] sum_q;
    logic             sum_msb_q;
    logic [WIDTH-1:0] add_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;
    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;

    // Operand registers shift right each digit, so the active digit always sits at the bottom.
    prefix_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (sum_q[DIGIT-1:0]),
        .b    (add_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    assign in_ready = (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sum_q     <= '0;
            sum_msb_q <= 1'b0;
            add_q     <= '0;
            borrow_q  <= 1'b0;
            k_q       <= '0;
            out_valid <= 1'b0;
            diff_o    <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q     <= sum_i[WIDTH-1:0];
                        sum_msb_q <= sum_i[WIDTH];
                        add_q     <= addend_i;
                        borrow_q  <= 1'b0;
                        k_q       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    diff_o   <= (diff_o >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
                    sum_q    <= sum_q >> DIGIT;
                    add_q    <= add_q >> DIGIT;
                    borrow_q <= dig_bout;
                    k_q      <= k_q + 1'b1;
                    if (k_q == KW'(NDIG - 1)) begin
                        // A carry-out that the final borrow does not cancel means no valid operand exists.
                        err_o     <= sum_msb_q ^ dig_bout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PREFIX_SUB_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_o <= '0;
        end else if (state == DONE && out_ready && err_o && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prefix_sub_serial.sv
`timescale 1ns/1ps
module tb_prefix_sub_serial;

    typedef struct {
        logic [12:0] sum;
        logic [11:0] add;
        logic [11:0] diff;
        logic        err;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] sum_i;
    logic [11:0] addend_i;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] diff_o;
    logic        err_o;
`ifdef PREFIX_SUB_ERRCNT_EN
    logic [7:0]  err_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    prefix_sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_i     (sum_i),
        .addend_i  (addend_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_o    (diff_o),
`ifdef PREFIX_SUB_ERRCNT_EN
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
`else
        .err_o     (err_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the recovered operand is plain integer sum - addend; it must fit in 12 bits.
    function automatic void model(input logic [12:0] s, input logic [11:0] a,
                                  output logic [11:0] d, output logic e);
        int diff;
        diff = int'(s) - int'(a);
        d = 12'(diff);
        e = (diff < 0) || (diff >= 4096);
    endfunction

    function automatic void count_err(input logic e);
        if (e && exp_cnt < 255) exp_cnt++;
    endfunction

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic run_pair(input logic [12:0] s, input logic [11:0] a, input int hold,
                            input logic early_rdy, output logic [11:0] d, output logic e,
                            output int lat);
        int n;
        sum_i     = s;
        addend_i  = a;
        in_valid  = 1'b1;
        out_ready = early_rdy;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        d = diff_o;
        e = err_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_diff_stable", diff_o, d);
            check("hold_err_stable", err_o, e);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake_out_valid", out_valid, 0);
        check("post_handshake_in_ready", in_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [11:0] a, b, d, ed, x;
        logic [12:0] s;
        logic        e, ee, seen;
        int          lat;

        vecs[0] = '{13'h0579, 12'h123, 12'h456, 1'b0, 0};
        vecs[1] = '{13'h1000, 12'h001, 12'hFFF, 1'b0, 0};
        vecs[2] = '{13'h0000, 12'h001, 12'hFFF, 1'b1, 0};
        vecs[3] = '{13'h1800, 12'h100, 12'h700, 1'b1, 0};
        vecs[4] = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0, 5};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_i = '0; addend_i = '0;
        #1;
        check("in_ready_during_rst", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff_o, 0);
        check("rst_err", err_o, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            run_pair(vecs[i].sum, vecs[i].add, vecs[i].hold, 1'b0, d, e, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
            count_err(vecs[i].err);
        end

        // Reset during the second RUN cycle must discard the in-flight result.
        sum_i = 13'h0579; addend_i = 12'h123; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_in_ready_run", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_cnt = 0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_discarded", seen, 0);
        run_pair(13'h0002, 12'h001, 0, 1'b0, d, e, lat);
        check("midrst_next_diff", d, 12'h001);
        check("midrst_next_err", e, 0);
        check("midrst_next_latency", lat, 4);

        for (int i = 0; i < 10000; i++) begin
            a = 12'($urandom);
            b = 12'($urandom);
            if (i % 5 == 4) s = 13'($urandom);
            else            s = {1'b0, a} + {1'b0, b};
            model(s, a, ed, ee);
            run_pair(s, a, 0, 1'($urandom), d, e, lat);
            check("rand_diff", d, ed);
            check("rand_err", e, ee);
            check("rand_latency", lat, 4);
            if (i % 5 != 4) check("rand_recovers_b", d, b);
            count_err(ee);
        end

        for (int i = 0; i < 300; i++) begin
            a = 12'($urandom_range(0, 2047));
            x = 12'($urandom_range(int'(a), 4095));
            s = {1'b1, x};
            model(s, a, ed, ee);
            run_pair(s, a, 0, 1'b0, d, e, lat);
            check("bad_err", e, 1);
            check("bad_diff", d, ed);
            count_err(ee);
        end
`ifdef PREFIX_SUB_ERRCNT_EN
        check("err_cnt_saturated", err_cnt_o, exp_cnt);
        check("err_cnt_ff", err_cnt_o, 8'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
